// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM tile scheduler: parallelism defaults and FSM state encoding.
package gemm_pkg;

  localparam int unsigned RowParDefault = 4;
  localparam int unsigned ColParDefault = 16;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StSetup = 3'd1;
  localparam state_t StRead  = 3'd2;
  localparam state_t StDrain = 3'd3;
  localparam state_t StWrite = 3'd4;
  localparam state_t StDone  = 3'd5;

endpackage

// File: rtl/gemm_tile_scheduler_if.sv
// Job/SRAM bundle of the GEMM tile scheduler: host drives job parameters, scheduler drives
// operand/tile addresses and datapath strobes.
interface gemm_tile_scheduler_if #(
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 32
) ();

  logic                     start;
  logic [SizeAddrWidth-1:0] m_size;
  logic [SizeAddrWidth-1:0] k_size;
  logic [SizeAddrWidth-1:0] n_size;
  logic [AddrWidth-1:0]     a_addr;
  logic [AddrWidth-1:0]     b_addr;
  logic [AddrWidth-1:0]     c_addr;
  logic                     c_we;
  logic                     mac_en;
  logic                     acc_clear;
  logic                     busy;
  logic                     done;

  modport master (
    output start, m_size, k_size, n_size,
    input  a_addr, b_addr, c_addr, c_we, mac_en, acc_clear, busy, done
  );

  modport slave (
    input  start, m_size, k_size, n_size,
    output a_addr, b_addr, c_addr, c_we, mac_en, acc_clear, busy, done
  );

endinterface

// File: rtl/gemm_tile_counter.sv
// Nested mt/nt/k counters for the tile scheduler, with running address bases so the
// A/B/C addresses come out of adders rather than multipliers.
module gemm_tile_counter #(
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     k_step_i,
  input  logic                     tile_step_i,
  input  logic [SizeAddrWidth-1:0] k_size_i,
  input  logic [SizeAddrWidth-1:0] mt_total_i,
  input  logic [SizeAddrWidth-1:0] nt_total_i,
  output logic [AddrWidth-1:0]     a_addr_o,
  output logic [AddrWidth-1:0]     b_addr_o,
  output logic [AddrWidth-1:0]     c_addr_o,
  output logic                     k_first_o,
  output logic                     k_last_o,
  output logic                     tile_last_o
);

  logic [SizeAddrWidth-1:0] k_q, nt_q, mt_q;
  logic [AddrWidth-1:0]     a_base_q, b_base_q, c_idx_q;
  logic                     nt_last, mt_last;
  logic [AddrWidth-1:0]     k_trunc;

  assign k_trunc     = AddrWidth'(k_size_i);
  assign nt_last     = (nt_q == nt_total_i - SizeAddrWidth'(1));
  assign mt_last     = (mt_q == mt_total_i - SizeAddrWidth'(1));
  assign k_first_o   = (k_q == '0);
  assign k_last_o    = (k_q == k_size_i - SizeAddrWidth'(1));
  assign tile_last_o = nt_last && mt_last;

  // a_base tracks mt*K and b_base tracks nt*K, both modulo 2^AddrWidth.
  assign a_addr_o = a_base_q + AddrWidth'(k_q);
  assign b_addr_o = b_base_q + AddrWidth'(k_q);
  assign c_addr_o = c_idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q      <= '0;
      nt_q     <= '0;
      mt_q     <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_idx_q  <= '0;
    end else if (clear_i) begin
      k_q      <= '0;
      nt_q     <= '0;
      mt_q     <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_idx_q  <= '0;
    end else begin
      if (k_step_i) begin
        k_q <= k_last_o ? '0 : k_q + SizeAddrWidth'(1);
      end
      if (tile_step_i) begin
        // nt-inner traversal makes the C index simply the running tile count.
        c_idx_q <= c_idx_q + AddrWidth'(1);
        if (nt_last) begin
          nt_q     <= '0;
          b_base_q <= '0;
          mt_q     <= mt_q + SizeAddrWidth'(1);
          a_base_q <= a_base_q + k_trunc;
        end else begin
          nt_q     <= nt_q + SizeAddrWidth'(1);
          b_base_q <= b_base_q + k_trunc;
        end
      end
    end
  end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Output-stationary GEMM tile scheduler: walks RowPar x ColPar output tiles, streams K operand
// reads per tile into the MAC array and writes each finished tile back to C.
module gemm_tile_scheduler
  import gemm_pkg::*;
#(
  parameter int unsigned RowPar        = RowParDefault,
  parameter int unsigned ColPar        = ColParDefault,
  parameter int unsigned AddrWidth     = 12,
  parameter int unsigned SizeAddrWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     mac_en_o,
  output logic                     acc_clear_o,
  output logic                     busy_o,
  output logic                     done_o
);

  state_t                   state_q, state_d;
  logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_size_q;
  logic [SizeAddrWidth-1:0] mt_total_q, nt_total_q;
  logic [SizeAddrWidth-1:0] mt_total_d, nt_total_d;
  logic [AddrWidth-1:0]     a_hold_q, b_hold_q, c_hold_q;
  logic                     mac_en_q, acc_clr_q;

  logic                     in_read, in_write, in_setup, size_zero;
  logic [AddrWidth-1:0]     a_addr, b_addr, c_addr;
  logic                     k_first, k_last, tile_last;

  assign in_read   = (state_q == StRead);
  assign in_write  = (state_q == StWrite);
  assign in_setup  = (state_q == StSetup);
  assign size_zero = (m_size_q == '0) || (k_size_q == '0) || (n_size_q == '0);

  assign mt_total_d = (m_size_q + SizeAddrWidth'(RowPar - 1)) / SizeAddrWidth'(RowPar);
  assign nt_total_d = (n_size_q + SizeAddrWidth'(ColPar - 1)) / SizeAddrWidth'(ColPar);

  gemm_tile_counter #(
    .AddrWidth     (AddrWidth),
    .SizeAddrWidth (SizeAddrWidth)
  ) u_counter (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (in_setup),
    .k_step_i    (in_read),
    .tile_step_i (in_write),
    .k_size_i    (k_size_q),
    .mt_total_i  (mt_total_q),
    .nt_total_i  (nt_total_q),
    .a_addr_o    (a_addr),
    .b_addr_o    (b_addr),
    .c_addr_o    (c_addr),
    .k_first_o   (k_first),
    .k_last_o    (k_last),
    .tile_last_o (tile_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StSetup;
      StSetup: state_d = size_zero ? StDone : StRead;
      StRead:  if (k_last) state_d = StDrain;
      StDrain: state_d = StWrite;
      StWrite: state_d = tile_last ? StDone : StRead;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      m_size_q   <= '0;
      k_size_q   <= '0;
      n_size_q   <= '0;
      mt_total_q <= '0;
      nt_total_q <= '0;
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      c_hold_q   <= '0;
      mac_en_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && start_i) begin
        m_size_q <= M_size_i;
        k_size_q <= K_size_i;
        n_size_q <= N_size_i;
      end
      if (in_setup) begin
        mt_total_q <= mt_total_d;
        nt_total_q <= nt_total_d;
      end
      if (in_read) begin
        a_hold_q <= a_addr;
        b_hold_q <= b_addr;
      end
      if (in_write) begin
        c_hold_q <= c_addr;
      end
      // Operand data returns one cycle after its address, so the strobes lag READ by one.
      mac_en_q  <= in_read;
      acc_clr_q <= in_read && k_first;
    end
  end

  assign sram_a_addr_o = in_read ? a_addr : a_hold_q;
  assign sram_b_addr_o = in_read ? b_addr : b_hold_q;
  assign sram_c_addr_o = in_write ? c_addr : c_hold_q;
  assign sram_c_we_o   = in_write;
  assign mac_en_o      = mac_en_q;
  assign acc_clear_o   = acc_clr_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler: latency, address streams, tile order, zero-size,
// ignored starts and mid-job reset, against hand-computed values.
module tb_gemm_tile_scheduler;

  localparam int unsigned AW = 12;
  localparam int unsigned SW = 32;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gemm_tile_scheduler_if #(.AddrWidth(AW), .SizeAddrWidth(SW)) bus ();

  gemm_tile_scheduler #(
    .RowPar        (4),
    .ColPar        (16),
    .AddrWidth     (AW),
    .SizeAddrWidth (SW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (bus.start),
    .M_size_i      (bus.m_size),
    .K_size_i      (bus.k_size),
    .N_size_i      (bus.n_size),
    .sram_a_addr_o (bus.a_addr),
    .sram_b_addr_o (bus.b_addr),
    .sram_c_addr_o (bus.c_addr),
    .sram_c_we_o   (bus.c_we),
    .mac_en_o      (bus.mac_en),
    .acc_clear_o   (bus.acc_clear),
    .busy_o        (bus.busy),
    .done_o        (bus.done)
  );

  int done_lat, n_mac, n_runs, runs_bad, n_clr_bad, busy_drop;
  int a_q[$];
  int b_q[$];
  int c_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the job finished (or the bound expired).
  task automatic run_job(input int m, input int k, input int n, input int inject_cyc,
                         input bit start_at_done);
    int cyc, run_len, prev_a, prev_b;
    bit prev_mac;
    a_q.delete(); b_q.delete(); c_q.delete();
    done_lat = -1; n_mac = 0; n_runs = 0; runs_bad = 0; n_clr_bad = 0; busy_drop = 0;
    bus.m_size = m; bus.k_size = k; bus.n_size = n;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; run_len = 0; prev_mac = 1'b0; prev_a = 0; prev_b = 0;
    while (cyc < 20000) begin
      if (bus.mac_en) begin
        a_q.push_back(prev_a);
        b_q.push_back(prev_b);
        n_mac++;
        run_len++;
        if (bus.acc_clear !== !prev_mac) n_clr_bad++;
      end else begin
        if (bus.acc_clear) n_clr_bad++;
        if (prev_mac) begin
          n_runs++;
          if (run_len != k) runs_bad++;
          run_len = 0;
        end
      end
      if (bus.c_we) c_q.push_back(int'(bus.c_addr));
      if (!bus.busy) busy_drop++;
      prev_mac = bus.mac_en;
      prev_a   = int'(bus.a_addr);
      prev_b   = int'(bus.b_addr);
      if (bus.done) begin
        done_lat = cyc;
        break;
      end
      if (cyc == inject_cyc) begin
        bus.start = 1'b1;
        bus.m_size = 4; bus.k_size = 64; bus.n_size = 16;
      end
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end
    if (start_at_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_done", bus.busy, 0);
    chk("done_one_cycle", bus.done, 0);
    @(negedge clk);
    chk("idle_after_ignored_start", bus.busy, 0);
  endtask

  initial begin
    int bad;
    bit found;
    rst = 1'b1;
    bus.start = 1'b0; bus.m_size = '0; bus.k_size = '0; bus.n_size = '0;
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_mac_en", bus.mac_en, 0);
    chk("reset_a_addr", bus.a_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single tile, start pulsed again in the DONE cycle.
    run_job(4, 64, 16, -1, 1'b1);
    chk("j1_latency", done_lat, 68);
    chk("j1_mac_count", n_mac, 64);
    chk("j1_mac_runs", n_runs, 1);
    chk("j1_runs_bad", runs_bad, 0);
    chk("j1_acc_clear_bad", n_clr_bad, 0);
    chk("j1_busy_drop", busy_drop, 0);
    chk("j1_writes", c_q.size(), 1);
    chk("j1_c_addr0", c_q[0], 0);
    bad = 0;
    if (a_q.size() != 64) bad = 1;
    else for (int i = 0; i < 64; i++) if (a_q[i] != i || b_q[i] != i) bad++;
    chk("j1_ab_stream_bad", bad, 0);

    // 8x2 tiles with a start pulse mid-job (and different sizes) that must be ignored.
    run_job(32, 32, 32, 100, 1'b0);
    chk("j2_latency", done_lat, 546);
    chk("j2_mac_count", n_mac, 512);
    chk("j2_mac_runs", n_runs, 16);
    chk("j2_runs_bad", runs_bad, 0);
    chk("j2_acc_clear_bad", n_clr_bad, 0);
    chk("j2_writes", c_q.size(), 16);
    bad = 0;
    if (c_q.size() == 16) for (int i = 0; i < 16; i++) if (c_q[i] != i) bad++;
    chk("j2_c_order_bad", bad, 0);
    chk("j2_t5_a_first", a_q[160], 64);
    chk("j2_t5_a_last", a_q[191], 95);
    chk("j2_t5_b_first", b_q[160], 32);
    chk("j2_t5_b_last", b_q[191], 63);

    // Partial tiles: Mt=2, Nt=1.
    run_job(5, 30, 10, -1, 1'b0);
    chk("j3_latency", done_lat, 66);
    chk("j3_mac_count", n_mac, 60);
    chk("j3_writes", c_q.size(), 2);
    chk("j3_c_addr0", c_q[0], 0);
    chk("j3_c_addr1", c_q[1], 1);
    chk("j3_t1_a_first", a_q[30], 30);
    chk("j3_t1_b_first", b_q[30], 0);

    // K = 0 goes straight from SETUP to DONE.
    run_job(4, 0, 16, -1, 1'b0);
    chk("k0_latency", done_lat, 2);
    chk("k0_mac_count", n_mac, 0);
    chk("k0_writes", c_q.size(), 0);

    // Reset at k = 10 of a running job.
    bus.m_size = 4; bus.k_size = 64; bus.n_size = 16;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy && bus.a_addr == 10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rst_reached_k10", found, 1);
    chk("rst_pre_mac_en", bus.mac_en, 1);
    rst = 1'b1;
    #1;
    chk("rst_mac_en", bus.mac_en, 0);
    chk("rst_acc_clear", bus.acc_clear, 0);
    chk("rst_c_we", bus.c_we, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_a_addr", bus.a_addr, 0);
    chk("rst_b_addr", bus.b_addr, 0);
    chk("rst_c_addr", bus.c_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_job(5, 30, 10, -1, 1'b0);
    chk("post_rst_latency", done_lat, 66);
    chk("post_rst_writes", c_q.size(), 2);
    chk("post_rst_mac_count", n_mac, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
